// File: rtl/hack_keyboard.sv
// PS/2 event word to Hack KBD register: decodes set-2 scancodes into Hack key codes,
// tracking Shift and Caps Lock, with a two-cycle event-to-output pipeline.
module hack_keyboard #(
  parameter bit CAPS_ENABLE = 1'b1,
  parameter int ESC_CODE    = 140
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic [15:0] key_code,
  output logic        key_event,
  output logic        shift_held,
  output logic        caps_lock
);

  localparam logic [7:0] ESC8 = 8'(ESC_CODE);

  logic       tog_q;
  logic       ev_p0;
  logic       vld_p1;
  logic       make_p1;
  logic       ext_p1;
  logic [7:0] sc_p1;
  logic [8:0] lut_p1;
  logic       mapped_p1;
  logic [7:0] code_p1;
  logic       is_lsh;
  logic       is_rsh;
  logic       is_caps;
  logic       hit_held;
  logic       lsh;
  logic       rsh;
  logic       caps_q;
  logic [7:0] code_q;
  logic       event_q;
  logic       held_ext;
  logic [7:0] held_sc;
  logic       held_vld;

  function automatic logic [8:0] letter_lut(input logic [7:0] sc, input logic upper);
    logic [7:0] lc;
    logic       hit;
    hit = 1'b1;
    case (sc)
      8'h1C: lc = "a";
      8'h32: lc = "b";
      8'h21: lc = "c";
      8'h23: lc = "d";
      8'h24: lc = "e";
      8'h2B: lc = "f";
      8'h34: lc = "g";
      8'h33: lc = "h";
      8'h43: lc = "i";
      8'h3B: lc = "j";
      8'h42: lc = "k";
      8'h4B: lc = "l";
      8'h3A: lc = "m";
      8'h31: lc = "n";
      8'h44: lc = "o";
      8'h4D: lc = "p";
      8'h15: lc = "q";
      8'h2D: lc = "r";
      8'h1B: lc = "s";
      8'h2C: lc = "t";
      8'h3C: lc = "u";
      8'h2A: lc = "v";
      8'h1D: lc = "w";
      8'h22: lc = "x";
      8'h35: lc = "y";
      8'h1A: lc = "z";
      default: begin
        lc  = 8'h00;
        hit = 1'b0;
      end
    endcase
    return {hit, upper ? (lc - 8'd32) : lc};
  endfunction

  function automatic logic [8:0] digit_lut(input logic [7:0] sc, input logic shift);
    logic [7:0] c;
    logic       hit;
    hit = 1'b1;
    case (sc)
      8'h16: c = shift ? "!" : "1";
      8'h1E: c = shift ? "@" : "2";
      8'h26: c = shift ? "#" : "3";
      8'h25: c = shift ? "$" : "4";
      8'h2E: c = shift ? "%" : "5";
      8'h36: c = shift ? "^" : "6";
      8'h3D: c = shift ? "&" : "7";
      8'h3E: c = shift ? "*" : "8";
      8'h46: c = shift ? "(" : "9";
      8'h45: c = shift ? ")" : "0";
      default: begin
        c   = 8'h00;
        hit = 1'b0;
      end
    endcase
    return {hit, c};
  endfunction

  // Punctuation follows Shift only; Caps Lock is deliberately ignored here.
  function automatic logic [8:0] punct_lut(input logic [7:0] sc, input logic shift);
    logic [7:0] c;
    logic       hit;
    hit = 1'b1;
    case (sc)
      8'h4E: c = shift ? "_"   : "-";
      8'h55: c = shift ? "+"   : "=";
      8'h54: c = shift ? "{"   : "[";
      8'h5B: c = shift ? "}"   : "]";
      8'h5D: c = shift ? "|"   : 8'h5C;
      8'h4C: c = shift ? ":"   : ";";
      8'h52: c = shift ? 8'h22 : 8'h27;
      8'h41: c = shift ? "<"   : ",";
      8'h49: c = shift ? ">"   : ".";
      8'h4A: c = shift ? "?"   : "/";
      8'h0E: c = shift ? "~"   : 8'h60;
      default: begin
        c   = 8'h00;
        hit = 1'b0;
      end
    endcase
    return {hit, c};
  endfunction

  function automatic logic [8:0] named_lut(input logic [7:0] sc);
    logic [7:0] c;
    logic       hit;
    hit = 1'b1;
    case (sc)
      8'h29: c = 8'd32;
      8'h5A: c = 8'd128;
      8'h66: c = 8'd129;
      8'h76: c = ESC8;
      8'h05: c = 8'd141;
      8'h06: c = 8'd142;
      8'h04: c = 8'd143;
      8'h0C: c = 8'd144;
      8'h03: c = 8'd145;
      8'h0B: c = 8'd146;
      8'h83: c = 8'd147;
      8'h0A: c = 8'd148;
      8'h01: c = 8'd149;
      8'h09: c = 8'd150;
      8'h78: c = 8'd151;
      8'h07: c = 8'd152;
      default: begin
        c   = 8'h00;
        hit = 1'b0;
      end
    endcase
    return {hit, c};
  endfunction

  function automatic logic [8:0] ext_lut(input logic [7:0] sc);
    logic [7:0] c;
    logic       hit;
    hit = 1'b1;
    case (sc)
      8'h5A: c = 8'd128;
      8'h6B: c = 8'd130;
      8'h75: c = 8'd131;
      8'h74: c = 8'd132;
      8'h72: c = 8'd133;
      8'h6C: c = 8'd134;
      8'h69: c = 8'd135;
      8'h7D: c = 8'd136;
      8'h7A: c = 8'd137;
      8'h70: c = 8'd138;
      8'h71: c = 8'd139;
      default: begin
        c   = 8'h00;
        hit = 1'b0;
      end
    endcase
    return {hit, c};
  endfunction

  function automatic logic [8:0] key_lut(input logic ext, input logic [7:0] sc,
                                         input logic shift, input logic caps);
    logic [8:0] r;
    if (ext) begin
      r = ext_lut(sc);
    end else begin
      r = letter_lut(sc, shift ^ caps);
      if (!r[8]) r = digit_lut(sc, shift);
      if (!r[8]) r = punct_lut(sc, shift);
      if (!r[8]) r = named_lut(sc);
    end
    return r;
  endfunction

  // Stage 0: event detect on the toggle bit, capture payload
  assign ev_p0 = ps2_key[10] ^ tog_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tog_q   <= ps2_key[10];
      vld_p1  <= 1'b0;
      make_p1 <= 1'b0;
      ext_p1  <= 1'b0;
      sc_p1   <= 8'h00;
    end else begin
      tog_q  <= ps2_key[10];
      vld_p1 <= ev_p0;
      if (ev_p0) begin
        make_p1 <= ps2_key[9];
        ext_p1  <= ps2_key[8];
        sc_p1   <= ps2_key[7:0];
      end
    end
  end

  // Stage 1: lookup, modifier tracking, held-key update
  always_comb begin
    lut_p1    = key_lut(ext_p1, sc_p1, lsh | rsh, caps_q);
    mapped_p1 = lut_p1[8];
    code_p1   = lut_p1[7:0];
    is_lsh    = !ext_p1 && (sc_p1 == 8'h12);
    is_rsh    = !ext_p1 && (sc_p1 == 8'h59);
    is_caps   = !ext_p1 && (sc_p1 == 8'h58);
    hit_held  = held_vld && ({ext_p1, sc_p1} == {held_ext, held_sc});
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lsh      <= 1'b0;
      rsh      <= 1'b0;
      caps_q   <= 1'b0;
      code_q   <= 8'h00;
      event_q  <= 1'b0;
      held_ext <= 1'b0;
      held_sc  <= 8'h00;
      held_vld <= 1'b0;
    end else begin
      event_q <= 1'b0;
      if (vld_p1) begin
        if (is_lsh) begin
          lsh <= make_p1;
        end else if (is_rsh) begin
          rsh <= make_p1;
        end else if (is_caps) begin
          if (make_p1 && CAPS_ENABLE) caps_q <= ~caps_q;
        end else if (make_p1) begin
          // Typematic repeats carry the same code and must not re-pulse.
          if (mapped_p1 && (code_p1 != code_q)) begin
            code_q   <= code_p1;
            held_ext <= ext_p1;
            held_sc  <= sc_p1;
            held_vld <= 1'b1;
            event_q  <= 1'b1;
          end
        end else if (hit_held) begin
          code_q   <= 8'h00;
          held_vld <= 1'b0;
          event_q  <= 1'b1;
        end
      end
    end
  end

  assign key_code   = {8'h00, code_q};
  assign key_event  = event_q;
  assign shift_held = lsh | rsh;
  assign caps_lock  = caps_q;

endmodule

// File: doc/hack_keyboard.md
Name: hack_keyboard

Overview:
- Consumes the 11-bit `ps2_key` event word that hps_io drives, and maintains the Hack KBD register, which the CPU reads at address 24576.
- `key_code` holds the Hack code of the key currently held. It is 0 when no mapped key is held.
- Tracks Shift and Caps Lock state so that letters and symbols produce the correct ASCII code.
- Sits inside `Nand2Tetris_top`, between the `ps2_key` input and the memory-mapped I/O decode.

Parameters:
- CAPS_ENABLE, 1: when 1, Caps Lock toggles letter case; when 0, scancode 0x58 is ignored.
- ESC_CODE, 140: Hack code emitted for Esc (scancode 0x76).

Ports:
- clk  in  1  system clock (`clk_sys`).
- reset_n  in  1  reset, synchronous, active-low.
- ps2_key  in  11  bit [10] toggles once per event; [9] 1=make, 0=break; [8] E0-extended; [7:0] set-2 scancode.
- key_code  out  16  Hack KBD value; bits [15:8] always 0.
- key_event  out  1  one-cycle pulse whenever `key_code` changes value.
- shift_held  out  1  Left Shift or Right Shift currently held.
- caps_lock  out  1  Caps Lock latch state.

Behaviour:
- Reset (`reset_n`=0 sampled at a clk edge):
  - `key_code`=0, `key_event`=0, `shift_held`=0, `caps_lock`=0.
  - Held-key register {ext,sc}=0; held-valid=0; pipeline stage cleared.
  - `tog_q` loads `ps2_key[10]` on every reset cycle, so no spurious event fires after reset releases.
  - A reset arriving mid-event drops that event.
- Event detect (cycle N): `ev = ps2_key[10] ^ tog_q`. `tog_q <= ps2_key[10]` every cycle. When `ev`=1, the payload `ps2_key[9:0]` is latched into stage 1.
- Stage 1 (cycle N+1): the combinational lookup produces `{mapped, code[7:0]}` from {ext, sc, shift, caps}. `key_code`/`key_event` are registered at the end of N+1.
- Latency: `key_code` changes and `key_event`=1 during cycle N+2. Throughput is one event per clk; back-to-back toggles are processed in order.
- Modifiers (non-extended): update flags only and never change `key_code`.
  - 0x12 (Left Shift) sets or clears `lsh`; 0x59 (Right Shift) sets or clears `rsh`. `shift_held = lsh|rsh`.
  - 0x58 (Caps Lock) on make: `caps_lock <= ~caps_lock` if CAPS_ENABLE. Caps Lock break is ignored.
- Map, US layout:
  - Letters (0x1C=a, 0x32=b ... 0x1A=z): uppercase when `shift^caps`.
  - Digit row 0x16..0x45: '1'..'0', or the shifted symbols !@#$%^&*() when shift is held.
  - Punctuation: `-=[]\;',./` and backtick, each with its shifted form; shift only, caps has no effect.
  - Named keys: Space 0x29→32; Enter 0x5A or E0 5A→128; Backspace 0x66→129; Esc 0x76→ESC_CODE.
  - E0-extended keys: 6B→130 (Left), 75→131 (Up), 74→132 (Right), 72→133 (Down), 6C→134 (Home), 69→135 (End), 7D→136 (PgUp), 7A→137 (PgDn), 70→138 (Insert), 71→139 (Delete).
  - Function keys F1..F12, scancodes 05,06,04,0C,03,0B,83,0A,01,09,78,07 → 141..152.
  - Everything else, including Ctrl/Alt: unmapped.
- Make of a mapped key:
  - If `code != key_code`: `key_code <= code`, held={ext,sc}, held-valid=1, and `key_event` pulses.
  - If `code == key_code` (typematic repeat): no change and no pulse.
- Break:
  - If held-valid and {ext,sc}==held: `key_code <= 0`, held-valid=0, and `key_event` pulses.
  - Break of any other key: ignored, `key_code` unchanged.
- Unmapped make: ignored. The held key is unchanged.
- Shift or caps change while a key is held: `key_code` is not recomputed; the code latched at make stays.
- Rollover: a new mapped make replaces the held key. Releasing the older key then does not clear `key_code`.

Test Plan:
1. Reset, then toggle `ps2_key` with {make=1, ext=0, sc=0x1C} → `key_code`=97 and `key_event`=1 exactly 2 clks after the toggle. Then break 0x1C → `key_code`=0 and `key_event` pulses.
2. Make 0x12, then make 0x1C → `shift_held`=1 and `key_code`=65. Make 0x58 with Shift still held, then make 0x1C again → 97 (`shift^caps`=0). Make 0x16 → 33 ('!').
3. Extended make E0 75 → 131. Non-extended make 0x75 (keypad 8) → unmapped, `key_code` stays 131. Break E0 75 → 0.
4. Make 0x1C three times (typematic) → `key_code`=97 with a single `key_event` pulse. Then make 0x32 → 98. Break 0x1C → `key_code` stays 98. Break 0x32 → 0.
5. Toggles on two consecutive clks (make 0x05, then make 0x07) → `key_code`=141 at N+2 and 152 at N+3, each with a `key_event` pulse.
6. Hold F1 (`key_code`=141) and `caps_lock`=1, then assert `reset_n`=0 for 1 clk while a toggle is in flight → all outputs 0 and no `key_event` after release. Then make 0x5A → 128.
